// File: rtl/rfphoenix_issue_sched.sv
// Per-cycle round-robin issue scheduler for the multithreaded rfPhoenix core.
// Picks one eligible thread per cycle, tracks per-thread flush windows and post-grant cooldown.
module rfphoenix_issue_sched #(
    parameter int NTHREADS     = 4,
    parameter int FLUSH_CYCLES = 5,
    parameter int COOLDOWN     = 1,
    localparam int TW          = $clog2(NTHREADS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NTHREADS-1:0] thrd_v,
    input  logic [NTHREADS-1:0] thrd_can_issue,
    input  logic                ex_ready,
    input  logic                rollback,
    input  logic [TW-1:0]       rollback_thrd,
    output logic [NTHREADS-1:0] will_issue,
    output logic                issue_v,
    output logic [TW-1:0]       issue_thrd,
    output logic [NTHREADS-1:0] flushing
);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;
    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);
    localparam logic [1:0] COOL_LOAD  = 2'(COOLDOWN);

    logic [NTHREADS-1:0] state_q, state_d;
    logic [3:0]          flush_cnt_q [NTHREADS];
    logic [3:0]          flush_cnt_d [NTHREADS];
    logic [1:0]          cool_q [NTHREADS];
    logic [1:0]          cool_d [NTHREADS];
    logic [TW-1:0]       rr_q, rr_d;
    logic                issue_v_q, issue_v_d;
    logic [TW-1:0]       issue_thrd_q, issue_thrd_d;

    logic [NTHREADS-1:0] eligible;
    logic [NTHREADS-1:0] grant;
    logic [TW-1:0]       grant_idx;
    logic [TW-1:0]       search_idx;
    logic                grant_any;

    // A thread being rolled back this cycle is masked so the grant falls through to the next one.
    always_comb begin
        eligible = '0;
        for (int t = 0; t < NTHREADS; t++) begin
            eligible[t] = thrd_v[t] & thrd_can_issue[t] & (state_q[t] == ST_RUN) &
                          (cool_q[t] == 2'd0) & ~(rollback && (rollback_thrd == TW'(t)));
        end
    end

    // NTHREADS is a power of two, so the TW-bit add wraps the search modulo NTHREADS.
    always_comb begin
        grant_any  = 1'b0;
        grant_idx  = '0;
        search_idx = '0;
        for (int i = 0; i < NTHREADS; i++) begin
            search_idx = rr_q + TW'(i);
            if (ex_ready && !rst && !grant_any && eligible[search_idx]) begin
                grant_any = 1'b1;
                grant_idx = search_idx;
            end
        end
        grant = grant_any ? (NTHREADS'(1) << grant_idx) : '0;
    end

    always_comb begin
        state_d      = state_q;
        rr_d         = grant_any ? (grant_idx + TW'(1)) : rr_q;
        issue_v_d    = grant_any;
        issue_thrd_d = grant_idx;
        for (int t = 0; t < NTHREADS; t++) begin
            flush_cnt_d[t] = flush_cnt_q[t];
            cool_d[t]      = cool_q[t];
            if (rollback && (rollback_thrd == TW'(t))) begin
                state_d[t]     = ST_FLUSH;
                flush_cnt_d[t] = FLUSH_LOAD;
                cool_d[t]      = 2'd0;
            end else begin
                if (grant[t]) begin
                    cool_d[t] = COOL_LOAD;
                end else if (cool_q[t] != 2'd0) begin
                    cool_d[t] = cool_q[t] - 2'd1;
                end
                if (state_q[t] == ST_FLUSH) begin
                    if (flush_cnt_q[t] <= 4'd1) begin
                        state_d[t]     = ST_RUN;
                        flush_cnt_d[t] = 4'd0;
                    end else begin
                        flush_cnt_d[t] = flush_cnt_q[t] - 4'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= '0;
            rr_q         <= '0;
            issue_v_q    <= 1'b0;
            issue_thrd_q <= '0;
            for (int t = 0; t < NTHREADS; t++) begin
                flush_cnt_q[t] <= 4'd0;
                cool_q[t]      <= 2'd0;
            end
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            issue_v_q    <= issue_v_d;
            issue_thrd_q <= issue_thrd_d;
            for (int t = 0; t < NTHREADS; t++) begin
                flush_cnt_q[t] <= flush_cnt_d[t];
                cool_q[t]      <= cool_d[t];
            end
        end
    end

    always_comb begin
        flushing = '0;
        for (int t = 0; t < NTHREADS; t++) begin
            flushing[t] = (state_q[t] == ST_FLUSH);
        end
    end

    assign will_issue = grant;
    assign issue_v    = issue_v_q;
    assign issue_thrd = issue_thrd_q;

endmodule

// File: tb/tb_rfphoenix_issue_sched.sv
// Testbench for rfphoenix_issue_sched: directed scenarios plus random traffic against a
// timestamp-based reference model (flush end cycle / next eligible cycle per thread).
module tb_rfphoenix_issue_sched;

    localparam int N  = 4;
    localparam int FC = 5;
    localparam int CD = 1;
    localparam int TW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  thrd_v;
    logic [N-1:0]  thrd_can_issue;
    logic          ex_ready;
    logic          rollback;
    logic [TW-1:0] rollback_thrd;
    logic [N-1:0]  will_issue;
    logic          issue_v;
    logic [TW-1:0] issue_thrd;
    logic [N-1:0]  flushing;

    int n_vectors     = 0;
    int n_miscompares = 0;

    int cyc;
    int flush_until [N];
    int next_ok [N];
    int m_rr;
    bit m_issue_v;
    int m_issue_thrd;

    logic [N-1:0] seen_will;
    logic [N-1:0] seen_flush;

    rfphoenix_issue_sched #(
        .NTHREADS(N),
        .FLUSH_CYCLES(FC),
        .COOLDOWN(CD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .thrd_v(thrd_v),
        .thrd_can_issue(thrd_can_issue),
        .ex_ready(ex_ready),
        .rollback(rollback),
        .rollback_thrd(rollback_thrd),
        .will_issue(will_issue),
        .issue_v(issue_v),
        .issue_thrd(issue_thrd),
        .flushing(flushing)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vectors++;
        assert (obs === exp) else begin
            n_miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        cyc = 0;
        for (int t = 0; t < N; t++) begin
            flush_until[t] = -1;
            next_ok[t]     = 0;
        end
        m_rr         = 0;
        m_issue_v    = 1'b0;
        m_issue_thrd = 0;
    endtask

    // Thread t may issue when its flush window is over and its cooldown time has come.
    function automatic int model_grant();
        int t;
        if (!ex_ready) return -1;
        for (int i = 0; i < N; i++) begin
            t = (m_rr + i) % N;
            if (thrd_v[t] && thrd_can_issue[t] && (cyc > flush_until[t]) && (cyc >= next_ok[t]) &&
                !(rollback && (int'(rollback_thrd) == t)))
                return t;
        end
        return -1;
    endfunction

    task automatic apply_stimulus(input logic [N-1:0] v, input logic [N-1:0] can, input logic exr,
                                  input logic rb, input logic [TW-1:0] rbt);
        int g;
        logic [N-1:0] exp_will;
        logic [N-1:0] exp_flush;
        logic [N-1:0] one;
        thrd_v         = v;
        thrd_can_issue = can;
        ex_ready       = exr;
        rollback       = rb;
        rollback_thrd  = rbt;
        #1;
        one = 1;
        g = model_grant();
        exp_will = (g >= 0) ? (one << g) : '0;
        for (int t = 0; t < N; t++) exp_flush[t] = (cyc <= flush_until[t]);
        check_output("will_issue", will_issue, exp_will);
        check_output("issue_v", issue_v, m_issue_v);
        if (m_issue_v) check_output("issue_thrd", issue_thrd, m_issue_thrd);
        check_output("flushing", flushing, exp_flush);
        seen_will  = will_issue;
        seen_flush = flushing;
        @(posedge clk);
        if (g >= 0) begin
            next_ok[g] = cyc + CD + 1;
            m_rr       = (g + 1) % N;
        end
        if (rb) begin
            flush_until[rbt] = cyc + FC;
            next_ok[rbt]     = 0;
        end
        m_issue_v    = (g >= 0);
        m_issue_thrd = (g >= 0) ? g : 0;
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        thrd_v = '0; thrd_can_issue = '0; ex_ready = 1'b0; rollback = 1'b0; rollback_thrd = '0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int grants;
        int flush_hi;
        logic [N-1:0] rr_exp [6];
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};

        // Power-on reset values.
        thrd_v = '1; thrd_can_issue = '1; ex_ready = 1'b1; rollback = 1'b0; rollback_thrd = '0;
        rst = 1'b1;
        #2;
        check_output("rst_will_issue", will_issue, 0);
        check_output("rst_issue_v", issue_v, 0);
        check_output("rst_issue_thrd", issue_thrd, 0);
        check_output("rst_flushing", flushing, 0);
        do_reset();

        // Round-robin from reset with every thread eligible.
        for (int i = 0; i < 6; i++) begin
            apply_stimulus('1, '1, 1'b1, 1'b0, '0);
            check_output("rr_seq", seen_will, rr_exp[i]);
        end

        // Back-pressure with rr at 2: nothing issues, then t2 goes first.
        for (int i = 0; i < 3; i++) begin
            apply_stimulus('1, '1, 1'b0, 1'b0, '0);
            check_output("bp_hold", seen_will, 0);
        end
        apply_stimulus('1, '1, 1'b1, 1'b0, '0);
        check_output("bp_first", seen_will, 4'b0100);

        // Flush window on t1 while the others keep rotating.
        apply_stimulus('1, '1, 1'b1, 1'b1, 2'd1);
        flush_hi = 0;
        for (int i = 0; i < 9; i++) begin
            apply_stimulus('1, '1, 1'b1, 1'b0, '0);
            if (seen_flush[1]) flush_hi++;
        end
        check_output("flush_len", flush_hi, FC);

        // Single active thread under cooldown issues every other cycle.
        grants = 0;
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(4'b0100, '1, 1'b1, 1'b0, '0);
            if (seen_will != 0) grants++;
        end
        check_output("cool_grants", grants, 3);

        // Rollback of the thread that would win hands the grant to the next eligible one.
        do_reset();
        apply_stimulus(4'b0001, '1, 1'b1, 1'b0, '0);
        apply_stimulus(4'b1010, '1, 1'b1, 1'b1, 2'd1);
        check_output("simul_grant", seen_will, 4'b1000);
        apply_stimulus(4'b0000, '1, 1'b1, 1'b0, '0);
        check_output("simul_flush", seen_flush, 4'b0010);

        // Reset while t0 is mid-flush (counter at 3).
        do_reset();
        apply_stimulus(4'b0000, '1, 1'b1, 1'b1, 2'd0);
        apply_stimulus(4'b0000, '1, 1'b1, 1'b0, '0);
        apply_stimulus(4'b0010, '1, 1'b1, 1'b0, '0);
        #2;
        rst = 1'b1;
        #1;
        check_output("midrst_flushing", flushing, 0);
        check_output("midrst_issue_v", issue_v, 0);
        check_output("midrst_will", will_issue, 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        apply_stimulus(4'b0001, '1, 1'b1, 1'b0, '0);
        check_output("midrst_t0_grant", seen_will, 4'b0001);

        // Random traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            apply_stimulus(N'($urandom), N'($urandom), ($urandom_range(0, 7) != 0),
                           ($urandom_range(0, 9) == 0), TW'($urandom_range(0, N - 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule

// File: doc/rfphoenix_issue_sched.md
# rfPhoenix_issue_sched

Per-cycle issue scheduler for the multithreaded rfPhoenix core. It selects at most one thread per cycle whose decoded instruction is valid and whose register scoreboard reports `can_issue`, then drives that thread's scoreboard `will_issue`. It sequences post-rollback flush windows per thread and enforces a cooldown that covers the scoreboard's registered `can_issue` latency. It sits between the per-thread decode/scoreboard pairs and the shared execute pipeline.

## Interface
Parameters:
- NTHREADS, 4, number of hardware threads; power of two, 2..16
- FLUSH_CYCLES, 5, cycles a thread is held off after rollback; matches the scoreboard rollback depth; 1..15
- COOLDOWN, 1, cycles a thread is ineligible after a grant; 0..3

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- thrd_v  in  NTHREADS  per-thread decoded instruction valid
- thrd_can_issue  in  NTHREADS  per-thread scoreboard can_issue
- ex_ready  in  1  execute pipeline accepts an instruction this cycle
- rollback  in  1  rollback request
- rollback_thrd  in  $clog2(NTHREADS)  thread being rolled back
- will_issue  out  NTHREADS  one-hot (or zero) grant, combinational; wired to each scoreboard's will_issue
- issue_v  out  1  registered: an instruction was granted last cycle
- issue_thrd  out  $clog2(NTHREADS)  registered: thread granted last cycle
- flushing  out  NTHREADS  registered: thread is in its flush window

## Operation
- Per-thread state: RUN or FLUSH, with a flush counter (4 bits) and a cooldown counter (2 bits).
- eligible[t] = thrd_v[t] & thrd_can_issue[t] & state[t]==RUN & cool[t]==0 & ~(rollback & rollback_thrd==t).
- Arbitration: round-robin. Search starts at pointer `rr` and wraps modulo NTHREADS. The first eligible thread wins.
- A grant is made only when ex_ready=1. With ex_ready=0, will_issue=0 and no state changes except flush and cooldown counting.
- On a grant to thread g:
  - rr ← (g+1) mod NTHREADS
  - cool[g] ← COOLDOWN
- With no grant, rr is unchanged.
- cool[t] decrements each cycle while nonzero, saturating at 0.
- Rollback of thread r, sampled at a clock edge:
  - state[r] ← FLUSH
  - flush counter ← FLUSH_CYCLES
  - cool[r] ← 0
- A rollback to a thread already in FLUSH reloads its counter to FLUSH_CYCLES.
- In FLUSH the counter decrements each cycle. When the counter is 1 and decrements, state returns to RUN.
- flushing[t] = (state[t]==FLUSH).
- Simultaneous events:
  - Rollback of thread t in the same cycle that t would win: t is masked, and arbitration falls to the next eligible thread in the same cycle.
  - A rollback of another thread does not affect arbitration.
- Reset:
  - will_issue=0, issue_v=0, issue_thrd=0, flushing=0
  - rr=0, all states RUN, all counters 0
  - Reset mid-flush ends the flush immediately.

## Timing
- will_issue is a same-cycle combinational function of the inputs and registered state. It has no dependency on issue_v.
- issue_v and issue_thrd are registered copies of (|will_issue, encoded index) and appear 1 cycle after the grant.
- Rollback at edge N:
  - flushing[r] is high for exactly FLUSH_CYCLES cycles, N+1..N+FLUSH_CYCLES.
  - The earliest new grant to r is cycle N+FLUSH_CYCLES+1.
- Cooldown: a thread granted in cycle N is next eligible in cycle N+COOLDOWN+1. With COOLDOWN=1, a single active thread issues at most every other cycle.
- Throughput is at most one grant per cycle. With ≥2 eligible threads and COOLDOWN=1, a grant is made every cycle.

## Test plan
- **Round-robin:** all 4 threads have v=1 and can_issue=1, ex_ready=1, from reset. → Grants are t0,t1,t2,t3,t0,… every cycle; issue_thrd follows one cycle later.
- **Cooldown:** only t2 is eligible, continuously. → will_issue=4'b0100 on alternate cycles; issue_v toggles 1,0,1,0.
- **Flush window:** rollback t1 at edge N, all threads eligible. → flushing[1] high N+1..N+5; t1 not granted before N+6; the others keep rotating.
- **Back-pressure:** all eligible, rr=2, ex_ready=0 for 3 cycles. → will_issue=0 throughout; on ex_ready=1 the first grant is t2.
- **Simultaneous rollback/grant:** rr=1, t1 and t3 eligible, rollback t1 in that cycle. → will_issue=4'b1000; t1 enters FLUSH.
- **Reset mid-flush:** assert rst during t0's flush (counter=3). → flushing=0 and issue_v=0 immediately; after release, t0 is granted in the first cycle it is eligible.
